// File: rtl/icache_ctrl_pkg.sv
// Shared widths, state encoding and address-field helpers for the
// direct-mapped instruction cache controller and its storage array.
package icache_ctrl_pkg;

    // Cache geometry. LINE_WORDS and NUM_LINES must be powers of two.
    localparam int LINE_WORDS = 4;
    localparam int NUM_LINES  = 16;
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;

    // Derived widths: word select within a line, byte offset, index, tag.
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = 2 + WSEL_W;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    // A line address is the tag and index together (address without offset).
    localparam int LINE_W = ADDR_W - OFF_W;

    // Controller state. REFILL owns the memory port until the line is full
    // or a flush/invalidate aborts it.
    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Field view of a fetch address, most significant field first.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [WSEL_W-1:0] wsel;
        logic [1:0]        byte_off;
    } addr_fields_t;

    // Split an address into tag / index / word select / byte offset.
    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] a);
        return addr_fields_t'(a);
    endfunction

    // Rebuild a word address from a line address and a word select. The
    // word select is only WSEL_W bits wide, so it can never carry into the
    // line address.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [LINE_W-1:0] line,
                                                    input logic [WSEL_W-1:0] wsel);
        return {line, wsel, 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the instruction cache: one asynchronous
// read port by index, one synchronous word write, one tag/valid write, a
// single-line invalidate and a single-cycle clear of all valid bits.
module icache_array
    import icache_ctrl_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    // Read port (combinational)
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [WSEL_W-1:0] rd_wsel_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [WORD_W-1:0] rd_data_o,
    // Write port (all writes target wr_idx_i)
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic              word_we_i,
    input  logic [WSEL_W-1:0] wr_wsel_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              tag_we_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              line_inval_i,
    input  logic              clear_all_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [WORD_W-1:0]    data_q [NUM_LINES][LINE_WORDS];

    // Next valid vector: a global clear beats any per-line update.
    always_comb begin
        valid_d = valid_q;
        if (clear_all_i) begin
            valid_d = '0;
        end else begin
            if (line_inval_i) begin
                valid_d[wr_idx_i] = 1'b0;
            end
            if (tag_we_i) begin
                valid_d[wr_idx_i] = 1'b1;
            end
        end
    end

    // Valid bits are the only storage that needs a reset value.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage; contents are meaningless while the line is invalid.
    always_ff @(posedge clk_in) begin
        if (word_we_i) begin
            data_q[wr_idx_i][wr_wsel_i] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_wsel_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller. Hits are returned in the same
// cycle as the fetch request; a miss refills the whole line with
// back-to-back single-word requests on the memory instruction port.
//
// Handshakes:
//   fetch:  the fetcher holds fetch_valid/fetch_addr stable until a cycle
//           with fetch_ready=1 (the word is taken in that cycle) or until it
//           asserts rob_clear. fetch_inst is zero whenever fetch_ready is 0.
//   memory: mem_inst_valid/mem_inst_addr name the word wanted next. The
//           memory interface samples the address when it starts a request
//           and re-samples it in every cycle it returns mem_inst_ready, so
//           the address already points at the following word in a ready
//           cycle. mem_inst_ready is registered on the far side, which keeps
//           the ready -> valid/addr path free of combinational loops.
module icache_ctrl
    import icache_ctrl_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic              inval_all,
    // Fetch side
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [WORD_W-1:0] fetch_inst,
    // Memory instruction port
    output logic              mem_inst_valid,
    output logic [ADDR_W-1:0] mem_inst_addr,
    input  logic [WORD_W-1:0] mem_inst_result,
    input  logic              mem_inst_ready,
    // Debug visibility of the FSM
    output state_e            dbg_state_o,
    output logic [WSEL_W-1:0] dbg_cnt_o
);

    state_e            state_q, state_d;
    logic [WSEL_W-1:0] cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    addr_fields_t      fa;
    logic              unused_byte_off;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data;

    logic [IDX_W-1:0]  wr_idx;
    logic              word_we;
    logic              tag_we;
    logic              line_inval;
    logic              clear_all;

    logic              hit;
    logic              flush;
    logic              last_word;
    logic [WSEL_W-1:0] req_wsel;

    assign fa              = split_addr(fetch_addr);
    // Fetch addresses are word aligned; the byte offset carries no information.
    assign unused_byte_off = ^fa.byte_off;

    assign hit       = fetch_valid & rd_valid & (rd_tag == fa.tag);
    assign flush     = rob_clear | inval_all;
    assign last_word = (cnt_q == WSEL_W'(LINE_WORDS - 1));
    // Word select of the address on the memory port: in a ready cycle it
    // already names the next word. Wraps inside the line by construction.
    assign req_wsel  = cnt_q + WSEL_W'(mem_inst_ready);

    icache_array u_array (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rd_idx_i    (fa.idx),
        .rd_wsel_i   (fa.wsel),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_idx_i    (wr_idx),
        .word_we_i   (word_we),
        .wr_wsel_i   (cnt_q),
        .wr_data_i   (mem_inst_result),
        .tag_we_i    (tag_we),
        .wr_tag_i    (line_q[LINE_W-1:IDX_W]),
        .line_inval_i(line_inval),
        .clear_all_i (clear_all)
    );

    // Next-state, array write controls and port outputs. Flush and
    // invalidate act regardless of rdy_in; everything else waits for it.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        line_d         = line_q;
        fetch_ready    = 1'b0;
        fetch_inst     = '0;
        mem_inst_valid = 1'b0;
        mem_inst_addr  = '0;
        wr_idx         = line_q[IDX_W-1:0];
        word_we        = 1'b0;
        tag_we         = 1'b0;
        line_inval     = 1'b0;
        clear_all      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hit && rdy_in && !flush && !rst_in) begin
                    fetch_ready = 1'b1;
                    fetch_inst  = rd_data;
                end else if (fetch_valid && !hit && rdy_in && !flush) begin
                    // Start a refill: remember the line, drop its valid bit
                    // so a half-filled line can never hit.
                    line_d     = {fa.tag, fa.idx};
                    cnt_d      = '0;
                    wr_idx     = fa.idx;
                    line_inval = 1'b1;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                mem_inst_valid = !flush && !(last_word && mem_inst_ready);
                mem_inst_addr  = word_addr(line_q, req_wsel);
                if (rdy_in && !flush && mem_inst_ready) begin
                    word_we = 1'b1;
                    if (last_word) begin
                        tag_we  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d   = IDLE;
            cnt_d     = '0;
            clear_all = inval_all;
        end
    end

    // State, word counter and refill line address registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed testbench for icache_ctrl: a latency-programmable memory model
// answers refill requests, a scoreboard holds the expected fetch returns and
// memory request addresses, and monitors compare whenever the DUT presents
// a fetch return or a memory request.
module tb_icache_ctrl;
    import icache_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_in;
    logic              rdy_in;
    logic              rob_clear;
    logic              inval_all;
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [WORD_W-1:0] fetch_inst;
    logic              mem_inst_valid;
    logic [ADDR_W-1:0] mem_inst_addr;
    logic [WORD_W-1:0] mem_inst_result;
    logic              mem_inst_ready;
    state_e            dbg_state;
    logic [WSEL_W-1:0] dbg_cnt;

    // Memory model outputs; the memory interface stalls with rdy_in too.
    logic              mem_ready_q = 1'b0;
    logic [WORD_W-1:0] mem_data_q  = '0;
    assign mem_inst_ready  = mem_ready_q & rdy_in;
    assign mem_inst_result = mem_data_q;

    icache_ctrl dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear      (rob_clear),
        .inval_all      (inval_all),
        .fetch_valid    (fetch_valid),
        .fetch_addr     (fetch_addr),
        .fetch_ready    (fetch_ready),
        .fetch_inst     (fetch_inst),
        .mem_inst_valid (mem_inst_valid),
        .mem_inst_addr  (mem_inst_addr),
        .mem_inst_result(mem_inst_result),
        .mem_inst_ready (mem_inst_ready),
        .dbg_state_o    (dbg_state),
        .dbg_cnt_o      (dbg_cnt)
    );

    // ---------------- scoreboard ----------------
    int                errors = 0;
    int                checks = 0;
    logic [WORD_W-1:0] exp_inst_q[$];
    logic [ADDR_W-1:0] exp_req_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: line 0 holds 0x11..0x44, everything else is tagged by address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return 32'h11 * ((a >> 2) + 1);
        return 32'hA000_0000 | a;
    endfunction

    // Fetch-return monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_in) begin
                if (fetch_ready) begin
                    if (exp_inst_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch_ready: got inst 0x%08h, expected no return (t=%0t)",
                                 fetch_inst, $time);
                    end else begin
                        check("fetch_inst", fetch_inst, exp_inst_q.pop_front());
                    end
                end else begin
                    check("fetch_inst_zero_when_not_ready", fetch_inst, 32'h0);
                end
            end
        end
    end

    // ---------------- memory model + request monitor ----------------
    int                mem_lat    = 0;
    int                ready_seen = 0;
    logic              mm_busy    = 1'b0;
    int                mm_wait    = 0;
    logic [ADDR_W-1:0] mm_addr    = '0;
    logic              mm_nxt_rdy = 1'b0;
    logic [WORD_W-1:0] mm_nxt_dat = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_in || rob_clear || inval_all) begin
                mm_busy    = 1'b0;
                mm_nxt_rdy = 1'b0;
            end else if (rdy_in) begin
                if (mem_inst_ready) ready_seen++;
                if (mem_inst_valid && (!mm_busy || mem_inst_ready)) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no request (t=%0t)",
                                 mem_inst_addr, $time);
                    end else begin
                        check("mem_req_addr", mem_inst_addr, exp_req_q.pop_front());
                    end
                    mm_addr = mem_inst_addr;
                    mm_busy = 1'b1;
                    mm_wait = mem_lat;
                end else if (mem_inst_ready) begin
                    mm_busy = 1'b0;
                end
                if (mm_busy && mm_wait == 0) begin
                    mm_nxt_rdy = 1'b1;
                    mm_nxt_dat = mem_word(mm_addr);
                end else begin
                    mm_nxt_rdy = 1'b0;
                    if (mm_busy) mm_wait--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ready_q = mm_nxt_rdy;
            mem_data_q  = mm_nxt_dat;
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one fetch, hold it until returned, check the cycles it waited.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_inst,
                            input bit miss, input int exp_lat);
        int n;
        bit got;
        logic [31:0] base;
        base = addr & ~32'(LINE_WORDS * 4 - 1);
        exp_inst_q.push_back(exp_inst);
        if (miss) begin
            for (int i = 0; i < LINE_WORDS; i++) exp_req_q.push_back(base + 32'(4 * i));
        end
        @(posedge clk);
        #1;
        fetch_addr  = addr;
        fetch_valid = 1'b1;
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (fetch_ready) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: no fetch_ready for addr 0x%08h within 80 cycles", addr);
        end else begin
            check("fetch_latency", 32'(n), 32'(exp_lat));
            if (!miss) check("hit_no_mem_req", {31'b0, mem_inst_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
    endtask

    // Wait (bounded) until n more memory readies have been taken.
    task automatic wait_readies(input int n);
        int base;
        bit ok;
        base = ready_seen;
        ok   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if (ready_seen - base >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: saw %0d readies, expected %0d", ready_seen - base, n);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        rob_clear   = 1'b0;
        inval_all   = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fetch_ready", {31'b0, fetch_ready}, 32'h0);
        check("rst_fetch_inst", fetch_inst, 32'h0);
        check("rst_mem_valid", {31'b0, mem_inst_valid}, 32'h0);
        check("rst_mem_addr", mem_inst_addr, 32'h0);
        check("rst_state", {31'b0, dbg_state}, {31'b0, IDLE});
        check("rst_cnt", 32'(dbg_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_in = 1'b0;

        // Cold miss with back-to-back readies, then same-cycle hits
        mem_lat = 0;
        do_fetch(32'h0000_0000, 32'h11, 1'b1, 6);
        do_fetch(32'h0000_0008, 32'h33, 1'b0, 0);
        do_fetch(32'h0000_000C, 32'h44, 1'b0, 0);

        // Conflict eviction (same index, different tag), slower memory
        mem_lat = 2;
        do_fetch(32'h0000_0100, 32'hA000_0100, 1'b1, 14);
        do_fetch(32'h0000_0104, 32'hA000_0104, 1'b0, 0);
        do_fetch(32'h0000_0000, 32'h11, 1'b1, 14);

        // rob_clear after 2 of 4 words; the ready in the clear cycle is dropped
        mem_lat = 0;
        exp_req_q.push_back(32'h0000_0200);
        exp_req_q.push_back(32'h0000_0204);
        exp_req_q.push_back(32'h0000_0208);
        @(posedge clk);
        #1;
        fetch_addr  = 32'h0000_0200;
        fetch_valid = 1'b1;
        wait_readies(2);
        @(posedge clk);
        #1;
        rob_clear   = 1'b1;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("clear_mem_valid", {31'b0, mem_inst_valid}, 32'h0);
        check("clear_fetch_ready", {31'b0, fetch_ready}, 32'h0);
        @(posedge clk);
        #1;
        rob_clear = 1'b0;
        @(negedge clk);
        check("clear_state", {31'b0, dbg_state}, {31'b0, IDLE});
        check("clear_cnt", 32'(dbg_cnt), 32'h0);
        check("clear_mem_valid_after", {31'b0, mem_inst_valid}, 32'h0);
        do_fetch(32'h0000_0040, 32'hA000_0040, 1'b1, 6);
        do_fetch(32'h0000_0208, 32'hA000_0208, 1'b1, 6);
        do_fetch(32'h0000_0000, 32'h11, 1'b1, 6);

        // rdy_in low for 3 cycles after the first refill word
        mem_lat = 1;
        fork
            do_fetch(32'h0000_0080, 32'hA000_0080, 1'b1, 13);
            begin
                wait_readies(1);
                @(posedge clk);
                #1;
                rdy_in = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_fetch_ready", {31'b0, fetch_ready}, 32'h0);
                    check("stall_state", {31'b0, dbg_state}, {31'b0, REFILL});
                    check("stall_cnt", 32'(dbg_cnt), 32'h1);
                    check("stall_mem_addr", mem_inst_addr, 32'h0000_0084);
                    check("stall_mem_valid", {31'b0, mem_inst_valid}, 32'h1);
                end
                @(posedge clk);
                #1;
                rdy_in = 1'b1;
            end
        join

        // A hit is held off while rdy_in is low
        @(posedge clk);
        #1;
        rdy_in      = 1'b0;
        fetch_addr  = 32'h0000_0084;
        fetch_valid = 1'b1;
        exp_inst_q.push_back(32'hA000_0084);
        @(negedge clk);
        check("stalled_hit_ready", {31'b0, fetch_ready}, 32'h0);
        @(posedge clk);
        #1;
        rdy_in = 1'b1;
        @(negedge clk);
        check("unstalled_hit_ready", {31'b0, fetch_ready}, 32'h1);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;

        // inval_all after lines 0 and 1 are filled
        mem_lat = 2;
        do_fetch(32'h0000_0010, 32'hA000_0010, 1'b1, 14);
        do_fetch(32'h0000_0000, 32'h11, 1'b0, 0);
        do_fetch(32'h0000_001C, 32'hA000_001C, 1'b0, 0);
        @(posedge clk);
        #1;
        fetch_addr  = 32'h0000_0000;
        fetch_valid = 1'b1;
        inval_all   = 1'b1;
        @(negedge clk);
        check("inval_fetch_ready", {31'b0, fetch_ready}, 32'h0);
        check("inval_mem_valid", {31'b0, mem_inst_valid}, 32'h0);
        @(posedge clk);
        #1;
        inval_all   = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("inval_state", {31'b0, dbg_state}, {31'b0, IDLE});
        do_fetch(32'h0000_0000, 32'h11, 1'b1, 14);
        do_fetch(32'h0000_0014, 32'hA000_0014, 1'b1, 14);

        // inval_all in the last-word ready cycle leaves the line invalid
        mem_lat = 0;
        exp_req_q.push_back(32'h0000_0030);
        exp_req_q.push_back(32'h0000_0034);
        exp_req_q.push_back(32'h0000_0038);
        exp_req_q.push_back(32'h0000_003C);
        @(posedge clk);
        #1;
        fetch_addr  = 32'h0000_0030;
        fetch_valid = 1'b1;
        wait_readies(3);
        @(posedge clk);
        #1;
        inval_all   = 1'b1;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("lastword_inval_cnt", 32'(dbg_cnt), 32'h3);
        check("lastword_inval_mem_valid", {31'b0, mem_inst_valid}, 32'h0);
        @(posedge clk);
        #1;
        inval_all = 1'b0;
        @(negedge clk);
        check("lastword_inval_state", {31'b0, dbg_state}, {31'b0, IDLE});
        do_fetch(32'h0000_0030, 32'hA000_0030, 1'b1, 6);

        // ---------------- final report ----------------
        repeat (3) @(negedge clk);
        check("exp_inst_q_drained", 32'(exp_inst_q.size()), 32'h0);
        check("exp_req_q_drained", 32'(exp_req_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time bound");
        $fatal(1, "watchdog expired");
    end

endmodule
